// File: rtl/pa_hash_ctrl.sv
// pa_hash_ctrl: Horner-form polynomial hash sequencer, acc <- reduce(acc*key + word),
// time-multiplexing one multiplier, one adder and one modular reducer across words.

// Single-stage registered 24x24 multiplier
module mult_gen_0 (
   input  logic        CLK,
   input  logic [23:0] A,
   input  logic [23:0] B,
   output logic [47:0] P
);
   // Product registered every cycle
   always_ff @(posedge CLK) P <= 48'(A) * 48'(B);
endmodule

// Single-stage registered adder with clock enable
module c_add_0 (
   input  logic        CLK,
   input  logic        CE,
   input  logic [47:0] A,
   input  logic [47:0] B,
   output logic [48:0] S
);
   // Sum captured only when enabled
   always_ff @(posedge CLK) if (CE) S <= 49'(A) + 49'(B);
endmodule

// Registered modular reduction of a 49-bit sum into the 24-bit field
module barret (
   input  logic        clk,
   input  logic [48:0] a_in,
   output logic [23:0] a_out
);
   localparam logic [48:0] MODULUS = 49'd16777213;

   // Reduced value registered every cycle
   always_ff @(posedge clk) a_out <= 24'(a_in % MODULUS);
endmodule

module pa_hash_ctrl #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_100Mhz,
   input  logic             rst_n,
   input  logic             start,
   input  logic [23:0]      key,
   input  logic [CNT_W-1:0] num_words,
   output logic             busy,
   input  logic [23:0]      word_in,
   input  logic             word_valid,
   output logic             word_ready,
   output logic [23:0]      hash_out,
   output logic             hash_valid
);
   localparam int unsigned DW = 24;
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = PW + 1;

   typedef enum logic [2:0] {IDLE, WAIT_W, MUL, ADD, RED, ACC} state_t;

   state_t           state, state_nxt;
   logic [DW-1:0]    key_r, key_nxt;
   logic [DW-1:0]    acc, acc_nxt;
   logic [DW-1:0]    w_r, w_nxt;
   logic [DW-1:0]    a_r, a_nxt;
   logic [DW-1:0]    b_r, b_nxt;
   logic [CNT_W-1:0] rem, rem_nxt;
   logic             busy_nxt, word_ready_nxt, hash_valid_nxt;
   logic [DW-1:0]    hash_out_nxt;

   logic [PW-1:0]    prod;
   logic [PW-1:0]    w_ext;
   logic [SW-1:0]    sum;
   logic [DW-1:0]    red;
   logic             add_ce_c;

   assign w_ext    = PW'(w_r);
   assign add_ce_c = (state == ADD);

   mult_gen_0 u_mult (
      .CLK (clk_100Mhz),
      .A   (a_r),
      .B   (b_r),
      .P   (prod)
   );

   c_add_0 u_add (
      .CLK (clk_100Mhz),
      .CE  (add_ce_c),
      .A   (prod),
      .B   (w_ext),
      .S   (sum)
   );

   barret u_red (
      .clk   (clk_100Mhz),
      .a_in  (sum),
      .a_out (red)
   );

   // Next-state, operand staging and registered-output values
   always_comb begin
      state_nxt      = state;
      key_nxt        = key_r;
      acc_nxt        = acc;
      w_nxt          = w_r;
      a_nxt          = a_r;
      b_nxt          = b_r;
      rem_nxt        = rem;
      busy_nxt       = busy;
      hash_out_nxt   = hash_out;
      hash_valid_nxt = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               if (num_words != '0) begin
                  key_nxt   = key;
                  rem_nxt   = num_words;
                  acc_nxt   = '0;
                  busy_nxt  = 1'b1;
                  state_nxt = WAIT_W;
               end else begin
                  // Empty job: hash of nothing is zero, reported immediately
                  hash_out_nxt   = '0;
                  hash_valid_nxt = 1'b1;
               end
            end
         end
         WAIT_W: begin
            if (word_valid && word_ready) begin
               a_nxt     = acc;
               b_nxt     = key_r;
               w_nxt     = word_in;
               state_nxt = MUL;
            end
         end
         MUL: state_nxt = ADD;
         ADD: state_nxt = RED;
         RED: state_nxt = ACC;
         ACC: begin
            acc_nxt = red;
            rem_nxt = rem - CNT_W'(1);
            if (rem == CNT_W'(1)) begin
               hash_out_nxt   = red;
               hash_valid_nxt = 1'b1;
               busy_nxt       = 1'b0;
               state_nxt      = IDLE;
            end else begin
               state_nxt = WAIT_W;
            end
         end
         default: state_nxt = IDLE;
      endcase

      word_ready_nxt = (state_nxt == WAIT_W);
   end

   // State and datapath registers; reset aborts any job in flight
   always_ff @(posedge clk_100Mhz or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         key_r      <= '0;
         acc        <= '0;
         w_r        <= '0;
         a_r        <= '0;
         b_r        <= '0;
         rem        <= '0;
         busy       <= 1'b0;
         word_ready <= 1'b0;
         hash_out   <= '0;
         hash_valid <= 1'b0;
      end else begin
         state      <= state_nxt;
         key_r      <= key_nxt;
         acc        <= acc_nxt;
         w_r        <= w_nxt;
         a_r        <= a_nxt;
         b_r        <= b_nxt;
         rem        <= rem_nxt;
         busy       <= busy_nxt;
         word_ready <= word_ready_nxt;
         hash_out   <= hash_out_nxt;
         hash_valid <= hash_valid_nxt;
      end
   end
endmodule

// File: tb/tb_pa_hash_ctrl.sv
// tb_pa_hash_ctrl: scoreboard bench for the polynomial hash controller.
module tb_pa_hash_ctrl;
   localparam int unsigned CNT_W = 16;
   localparam longint unsigned MODULUS = 64'd16777213;

   logic             clk_100Mhz;
   logic             rst_n;
   logic             start;
   logic [23:0]      key;
   logic [CNT_W-1:0] num_words;
   logic             busy;
   logic [23:0]      word_in;
   logic             word_valid;
   logic             word_ready;
   logic [23:0]      hash_out;
   logic             hash_valid;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int hv_count = 0;
   int busy_total = 0;
   logic [23:0] exp_q[$];

   pa_hash_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_100Mhz (clk_100Mhz),
      .rst_n      (rst_n),
      .start      (start),
      .key        (key),
      .num_words  (num_words),
      .busy       (busy),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .hash_out   (hash_out),
      .hash_valid (hash_valid)
   );

   initial begin
      clk_100Mhz = 1'b0;
      forever #5 clk_100Mhz = ~clk_100Mhz;
   end

   // Rising-edge counter used for latency measurements
   initial forever begin
      @(posedge clk_100Mhz);
      cyc = cyc + 1;
   end

   task automatic chk(input bit ok, input string name, input longint unsigned act,
                      input longint unsigned exp);
      n_chk++;
      if (!ok) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: Horner evaluation modulo the field prime
   function automatic logic [23:0] ref_hash(input logic [23:0] k, input logic [23:0] ws[$]);
      longint unsigned a = 0;
      foreach (ws[i]) a = (a * 64'(k) + 64'(ws[i])) % MODULUS;
      return 24'(a);
   endfunction

   // Monitor: every hash_valid pulse pops one expected hash
   initial forever begin
      @(negedge clk_100Mhz);
      if (busy) busy_total++;
      if (rst_n && hash_valid) begin
         hv_count++;
         if (exp_q.size() == 0) begin
            chk(1'b0, "spurious_hash", 64'(hash_out), 0);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            chk(hash_out == e, "hash_value", 64'(hash_out), 64'(e));
         end
      end
   end

   // Present one word; gap/late hold word_valid low after word_ready is seen
   task automatic send_word(input logic [23:0] w, input int gap, input int late, output int acc_cyc);
      int t = 0;
      bit at_neg = 1'b0;
      if (gap > 0 || late > 0) begin
         word_valid = 1'b0;
         do begin
            @(negedge clk_100Mhz);
            t++;
         end while (!word_ready && t < 100);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk_100Mhz);
            chk(word_ready == 1'b1, "park_ready", 64'(word_ready), 1);
         end
         repeat (late) @(negedge clk_100Mhz);
         at_neg = 1'b1;
      end
      word_valid = 1'b1;
      word_in    = w;
      t = 0;
      if (!at_neg) @(negedge clk_100Mhz);
      while (!word_ready && t < 100) begin
         @(negedge clk_100Mhz);
         t++;
      end
      if (!word_ready) begin
         chk(1'b0, "accept_timeout", 0, 1);
         word_valid = 1'b0;
         acc_cyc = -1;
         return;
      end
      @(posedge clk_100Mhz);
      #1;
      acc_cyc = cyc;
      word_valid = 1'b0;
   endtask

   task automatic run_job(input logic [23:0] k, input logic [23:0] ws[$], input int gap_idx,
                          input int gap, input int late, input bit intrude,
                          input int abort_after, output int busy_cycles);
      int n, acc_prev, a_c, start_cyc, hv0, bt0, t;
      n = ws.size();
      acc_prev = -1;
      busy_cycles = -1;
      @(negedge clk_100Mhz);
      start     = 1'b1;
      key       = k;
      num_words = CNT_W'(n);
      exp_q.push_back(ref_hash(k, ws));
      @(posedge clk_100Mhz);
      #1;
      start     = 1'b0;
      key       = 24'($urandom);
      num_words = CNT_W'($urandom);
      start_cyc = cyc;
      hv0       = hv_count;
      bt0       = busy_total;

      if (n == 0) begin
         @(negedge clk_100Mhz);
         chk(hash_valid == 1'b1, "zero_hv", 64'(hash_valid), 1);
         chk(busy == 1'b0, "zero_busy", 64'(busy), 0);
         chk(word_ready == 1'b0, "zero_ready", 64'(word_ready), 0);
         @(negedge clk_100Mhz);
         chk(hash_valid == 1'b0, "zero_hv_pulse", 64'(hash_valid), 0);
         chk(busy == 1'b0, "zero_busy2", 64'(busy), 0);
         chk(word_ready == 1'b0, "zero_ready2", 64'(word_ready), 0);
         return;
      end

      chk(word_ready == 1'b1, "ready_after_start", 64'(word_ready), 1);
      chk(busy == 1'b1, "busy_after_start", 64'(busy), 1);

      for (int i = 0; i < n; i++) begin
         if (i == abort_after) begin
            #2 rst_n = 1'b0;
            #1;
            chk(busy == 1'b0, "rst_busy", 64'(busy), 0);
            chk(word_ready == 1'b0, "rst_ready", 64'(word_ready), 0);
            chk(hash_valid == 1'b0, "rst_hv", 64'(hash_valid), 0);
            chk(hash_out == 24'd0, "rst_hash", 64'(hash_out), 0);
            void'(exp_q.pop_back());
            repeat (3) @(negedge clk_100Mhz);
            rst_n = 1'b1;
            return;
         end
         send_word(ws[i], (i == gap_idx) ? gap : 0, (i == 0) ? late : 0, a_c);
         if (a_c < 0) return;
         if (acc_prev >= 0 && i != gap_idx)
            chk(a_c - acc_prev == 5, "accept_spacing", 64'(a_c - acc_prev), 5);
         acc_prev = a_c;
         if (intrude && i == 0) begin
            start     = 1'b1;
            key       = 24'd9;
            num_words = CNT_W'(5);
            @(posedge clk_100Mhz);
            #1;
            start = 1'b0;
         end
      end

      t = 0;
      while (!hash_valid && t < 50) begin
         @(negedge clk_100Mhz);
         t++;
      end
      chk(hash_valid == 1'b1, "hv_timeout", 64'(hash_valid), 1);
      chk(cyc - acc_prev == 4, "hv_latency", 64'(cyc - acc_prev), 4);
      chk(busy == 1'b0, "busy_fall", 64'(busy), 0);
      busy_cycles = busy_total - bt0;
      chk(busy_cycles == acc_prev + 4 - start_cyc, "busy_len", 64'(busy_cycles),
          64'(acc_prev + 4 - start_cyc));
      @(negedge clk_100Mhz);
      chk(hash_valid == 1'b0, "hv_pulse", 64'(hash_valid), 0);
      if (intrude) begin
         repeat (20) @(negedge clk_100Mhz);
         chk(hv_count - hv0 == 1, "single_hv", 64'(hv_count - hv0), 1);
      end
   endtask

   // Watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [23:0] ws[$];
      int bc, n;
      rst_n = 1'b0; start = 1'b0; word_valid = 1'b0;
      key = '0; word_in = '0; num_words = '0;
      repeat (3) @(negedge clk_100Mhz);
      chk(busy == 1'b0, "reset_busy", 64'(busy), 0);
      chk(word_ready == 1'b0, "reset_ready", 64'(word_ready), 0);
      chk(hash_valid == 1'b0, "reset_hv", 64'(hash_valid), 0);
      chk(hash_out == 24'd0, "reset_hash", 64'(hash_out), 0);
      rst_n = 1'b1;

      ws = '{24'd1, 24'd2, 24'd3};
      run_job(24'd2, ws, -1, 0, 0, 1'b0, -1, bc);
      ws.delete();
      run_job(24'd123, ws, -1, 0, 0, 1'b0, -1, bc);
      ws = '{24'd1, 24'd2, 24'd3};
      run_job(24'd2, ws, 1, 7, 0, 1'b0, -1, bc);
      run_job(24'd2, ws, -1, 0, 0, 1'b1, -1, bc);
      run_job(24'd2, ws, -1, 0, 0, 1'b0, 2, bc);
      ws = '{24'd5, 24'd7};
      run_job(24'd3, ws, -1, 0, 0, 1'b0, -1, bc);
      // Word presented one cycle after word_ready rises
      ws = '{24'hABCDEF};
      run_job(24'h000100, ws, -1, 0, 1, 1'b0, -1, bc);
      chk(bc == 6, "busy_six", 64'(bc), 6);

      for (int j = 0; j < 10; j++) begin
         n = int'($urandom_range(1, 5));
         ws.delete();
         for (int i = 0; i < n; i++) ws.push_back(24'($urandom));
         run_job(24'($urandom), ws, int'($urandom_range(0, n - 1)), int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 1)), 1'b0, -1, bc);
      end

      repeat (10) @(negedge clk_100Mhz);
      chk(exp_q.size() == 0, "sb_drained", 64'(exp_q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
